// File: rtl/vctcxo_tamer_pps_counter.sv
// VCTCXO tamer PPS counter: counts clk cycles between 1PPS edges over 1 s, 10 s and 100 s
// windows and writes each signed error plus a status byte to register RAM. Macro: VCTCXO_TAMER_PPS_100S_EN.
module vctcxo_tamer_pps_counter #(
  parameter int EXPECTED_1S = 38400000,
  parameter int PPS_TIMEOUT = 76800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pps,
  input  logic       irq_clear,
  output logic [7:0] ram_address,
  output logic       ram_chipselect,
  output logic       ram_write,
  output logic [7:0] ram_writedata,
  output logic       irq
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMING   = 2'd1,
    COUNTING = 2'd2,
    WRITING  = 2'd3
  } state_t;

  localparam logic [31:0] EXP1_C    = 32'(EXPECTED_1S);
  localparam logic [31:0] EXP10_C   = 32'(64'(EXPECTED_1S) * 64'd10);
  localparam logic [31:0] TIMEOUT_C = 32'(PPS_TIMEOUT - 1);
`ifdef VCTCXO_TAMER_PPS_100S_EN
  localparam logic [31:0] EXP100_C  = 32'(64'(EXPECTED_1S) * 64'd100);
  localparam logic [2:0]  WIN_MASK_C = 3'b111;
`else
  localparam logic [2:0]  WIN_MASK_C = 3'b011;
`endif

  function automatic logic [1:0] first_pending(input logic [2:0] mask);
    if (mask[0]) return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic [2:0] later_mask(input logic [1:0] win);
    case (win)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  logic        pps_meta_r, pps_sync_r, pps_prev_r, pps_pulse_r;
  state_t      state_r, state_s;
  logic [1:0]  win_r, win_s, byte_r, byte_s;
  logic        lost_r, lost_s, lost_evt_s;
  logic [2:0]  pending_r, pending_s, upd_s, clr_pend_s, done_s;
  logic [7:0]  status_r, status_s, set_s;
  logic        irq_r, irq_s, overrun_s, status_wr_s;
  logic        ram_write_r, wr_s;
  logic [7:0]  ram_address_r, addr_s, ram_writedata_r, data_s;
  logic [31:0] cnt1_r, cnt10_r, err1_r, err10_r, word100_s;
  logic [3:0]  edges10_r;
  logic        counting_s, done1_s, done10_s, done100_s, timeout_s;

  assign counting_s  = ((state_r == COUNTING) || (state_r == WRITING)) && !lost_r;
  assign done1_s     = counting_s && pps_pulse_r;
  assign done10_s    = done1_s && (edges10_r == 4'd9);
  assign done_s      = {done100_s, done10_s, done1_s} & WIN_MASK_C;
  assign timeout_s   = (state_r == COUNTING) && !pps_pulse_r && (cnt1_r >= TIMEOUT_C);
  assign status_wr_s = (state_r == WRITING) && (win_r == 2'd3);

  // Two-flop synchroniser plus registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pps_meta_r  <= 1'b0;
      pps_sync_r  <= 1'b0;
      pps_prev_r  <= 1'b0;
      pps_pulse_r <= 1'b0;
    end else begin
      pps_meta_r  <= pps;
      pps_sync_r  <= pps_meta_r;
      pps_prev_r  <= pps_sync_r;
      pps_pulse_r <= pps_sync_r & ~pps_prev_r;
    end
  end

  // 1 s and 10 s window counters; the completing edge restarts the count at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_r    <= 32'd0;
      cnt10_r   <= 32'd0;
      edges10_r <= 4'd0;
      err1_r    <= 32'd0;
      err10_r   <= 32'd0;
    end else if ((state_r == DISABLED) || (state_r == ARMING)) begin
      cnt1_r    <= 32'd0;
      cnt10_r   <= 32'd0;
      edges10_r <= 4'd0;
    end else if (done1_s) begin
      cnt1_r <= 32'd0;
      err1_r <= cnt1_r + 32'd1 - EXP1_C;
      if (done10_s) begin
        cnt10_r   <= 32'd0;
        edges10_r <= 4'd0;
        err10_r   <= cnt10_r + 32'd1 - EXP10_C;
      end else begin
        cnt10_r   <= cnt10_r + 32'd1;
        edges10_r <= edges10_r + 4'd1;
      end
    end else begin
      cnt1_r  <= cnt1_r + 32'd1;
      cnt10_r <= cnt10_r + 32'd1;
    end
  end

`ifdef VCTCXO_TAMER_PPS_100S_EN
  logic [31:0] cnt100_r, err100_r;
  logic [6:0]  edges100_r;

  assign done100_s = done1_s && (edges100_r == 7'd99);
  assign word100_s = err100_r;

  // 100 s window counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt100_r   <= 32'd0;
      edges100_r <= 7'd0;
      err100_r   <= 32'd0;
    end else if ((state_r == DISABLED) || (state_r == ARMING)) begin
      cnt100_r   <= 32'd0;
      edges100_r <= 7'd0;
    end else if (done100_s) begin
      cnt100_r   <= 32'd0;
      edges100_r <= 7'd0;
      err100_r   <= cnt100_r + 32'd1 - EXP100_C;
    end else begin
      cnt100_r   <= cnt100_r + 32'd1;
      edges100_r <= done1_s ? edges100_r + 7'd1 : edges100_r;
    end
  end
`else
  assign done100_s = 1'b0;
  assign word100_s = 32'd0;
`endif

  // Next state; win/byte name the RAM byte presented in the following cycle
  always_comb begin
    state_s    = state_r;
    win_s      = win_r;
    byte_s     = byte_r;
    lost_s     = lost_r;
    upd_s      = 3'b000;
    clr_pend_s = 3'b000;
    lost_evt_s = 1'b0;
    if (!enable) begin
      state_s = DISABLED;
      win_s   = 2'd0;
      byte_s  = 2'd0;
      lost_s  = 1'b0;
    end else begin
      case (state_r)
        DISABLED: state_s = ARMING;
        ARMING: begin
          if (pps_pulse_r) state_s = COUNTING;
          else state_s = ARMING;
        end
        COUNTING: begin
          if (timeout_s) begin
            lost_evt_s = 1'b1;
            lost_s     = 1'b1;
            state_s    = WRITING;
            win_s      = 2'd3;
            byte_s     = 2'd0;
          end else if (|pending_r) begin
            state_s = WRITING;
            win_s   = first_pending(pending_r);
            byte_s  = 2'd0;
          end else begin
            state_s = COUNTING;
          end
        end
        WRITING: begin
          if (win_r == 2'd3) begin
            state_s = lost_r ? ARMING : COUNTING;
            win_s   = 2'd0;
            byte_s  = 2'd0;
            lost_s  = 1'b0;
          end else if (byte_r == 2'd3) begin
            upd_s      = 3'b001 << win_r;
            clr_pend_s = 3'b001 << win_r;
            win_s      = first_pending(pending_r & later_mask(win_r));
            byte_s     = 2'd0;
          end else begin
            byte_s = byte_r + 2'd1;
          end
        end
        default: state_s = DISABLED;
      endcase
    end
  end

  // Sticky status, pending flags, irq and the next RAM byte
  always_comb begin
    overrun_s = |(done_s & pending_r & ~clr_pend_s);
    set_s     = {overrun_s, lost_evt_s, 3'b000, upd_s & WIN_MASK_C};
    if (irq_clear && !status_wr_s) status_s = set_s;
    else status_s = status_r | set_s;
    if (status_wr_s) irq_s = 1'b1;
    else if (irq_clear) irq_s = 1'b0;
    else irq_s = irq_r;
    if ((state_s == DISABLED) || lost_evt_s) pending_s = 3'b000;
    else pending_s = ((pending_r & ~clr_pend_s) | done_s) & WIN_MASK_C;
    wr_s = (state_s == WRITING);
    if (wr_s) begin
      addr_s = {4'b0000, win_s, byte_s};
      case (win_s)
        2'd0:    data_s = byte_sel(err1_r, byte_s);
        2'd1:    data_s = byte_sel(err10_r, byte_s);
        2'd2:    data_s = byte_sel(word100_s, byte_s);
        default: data_s = status_s;
      endcase
    end else begin
      addr_s = 8'h00;
      data_s = 8'h00;
    end
  end

  // Control registers and registered RAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= DISABLED;
      win_r           <= 2'd0;
      byte_r          <= 2'd0;
      lost_r          <= 1'b0;
      pending_r       <= 3'b000;
      status_r        <= 8'h00;
      irq_r           <= 1'b0;
      ram_write_r     <= 1'b0;
      ram_address_r   <= 8'h00;
      ram_writedata_r <= 8'h00;
    end else begin
      state_r         <= state_s;
      win_r           <= win_s;
      byte_r          <= byte_s;
      lost_r          <= lost_s;
      pending_r       <= pending_s;
      status_r        <= status_s;
      irq_r           <= irq_s;
      ram_write_r     <= wr_s;
      ram_address_r   <= addr_s;
      ram_writedata_r <= data_s;
    end
  end

  assign ram_write      = ram_write_r;
  assign ram_chipselect = ram_write_r;
  assign ram_address    = ram_address_r;
  assign ram_writedata  = ram_writedata_r;
  assign irq            = irq_r;

endmodule

// File: tb/tb_vctcxo_tamer_pps_counter.sv
// Bench for vctcxo_tamer_pps_counter: directed and random PPS periods, with the expected
// RAM write stream derived from the period list by plain arithmetic.
module tb_vctcxo_tamer_pps_counter;
  localparam int E  = 100;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset, enable, pps, irq_clear;
  logic [7:0] ram_address, ram_writedata;
  logic       ram_chipselect, ram_write, irq;

  int          tests = 0;
  int          failed = 0;
  logic        mon_en = 1'b0;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  model_status;

  vctcxo_tamer_pps_counter #(.EXPECTED_1S(E), .PPS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pps(pps), .irq_clear(irq_clear),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus monitor: capture every write, police the idle bus
  always @(negedge clk) begin
    if (mon_en) begin
      check("cs_eq_write", {31'd0, ram_chipselect}, {31'd0, ram_write});
      if (ram_write === 1'b1) act_q.push_back({ram_address, ram_writedata});
      else check("idle_bus", {16'd0, ram_address, ram_writedata}, 32'd0);
    end
  end

  task automatic push_word(input logic [7:0] base, input int val);
    logic [31:0] w;
    w = val;
    for (int i = 0; i < 4; i++) exp_q.push_back({base + 8'(i), w[8*i +: 8]});
  endtask

  // Reference: edge k closes the 1 s window, every 10th (100th) edge the 10 s (100 s) window
  task automatic model_edges(input int per[$]);
    for (int k = 1; k <= per.size(); k++) begin
      logic [7:0] bits;
      int s;
      push_word(8'h00, per[k-1] - E);
      bits = 8'h01;
      if (k % 10 == 0) begin
        s = 0;
        for (int j = k - 10; j < k; j++) s += per[j];
        push_word(8'h04, s - 10 * E);
        bits |= 8'h02;
      end
`ifdef VCTCXO_TAMER_PPS_100S_EN
      if (k % 100 == 0) begin
        s = 0;
        for (int j = k - 100; j < k; j++) s += per[j];
        push_word(8'h08, s - 100 * E);
        bits |= 8'h04;
      end
`endif
      model_status |= bits;
      exp_q.push_back({8'h0C, model_status});
    end
  endtask

  task automatic drive_edges(input int per[$]);
    pps = 1'b1; tick(10); pps = 1'b0;
    foreach (per[i]) begin
      tick(per[i] - 10);
      pps = 1'b1; tick(10); pps = 1'b0;
    end
  endtask

  task automatic compare_writes(input string tag);
    int f0;
    f0 = failed;
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check({tag, "_write"}, {16'd0, act_q[i]}, {16'd0, exp_q[i]});
      if (failed != f0) break;
    end
  endtask

  task automatic start_phase();
    enable = 1'b0; tick(3);
    irq_clear = 1'b1; tick(1); irq_clear = 1'b0;
    model_status = 8'h00;
    act_q.delete();
    exp_q.delete();
    enable = 1'b1; tick(2);
  endtask

  task automatic run_phase(input string tag, input int per[$]);
    start_phase();
    model_edges(per);
    drive_edges(per);
    tick(50);
    compare_writes(tag);
  endtask

  initial begin
    int per[$];
    int hits;
    logic found;
    logic [7:0] last_status;

    // Reset dominates enable, pps and irq_clear
    reset = 1'b1; enable = 1'b1; pps = 1'b1; irq_clear = 1'b1;
    tick(3);
    check("rst_write", {31'd0, ram_write}, 32'd0);
    check("rst_cs", {31'd0, ram_chipselect}, 32'd0);
    check("rst_addr", {24'd0, ram_address}, 32'd0);
    check("rst_data", {24'd0, ram_writedata}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    pps = 1'b0; enable = 1'b0; irq_clear = 1'b0;
    tick(4);
    reset = 1'b0;
    mon_en = 1'b1;

    per = '{100};
    run_phase("nominal", per);
    check("nominal_irq", {31'd0, irq}, 32'd1);
    irq_clear = 1'b1; tick(1); irq_clear = 1'b0;
    check("nominal_irq_clr", {31'd0, irq}, 32'd0);

    per = '{103, 97};
    run_phase("pm3", per);

    per.delete();
    repeat (11 - 1) per.push_back(101);
    run_phase("win10", per);
    check("win10_irq", {31'd0, irq}, 32'd1);

    for (int r = 0; r < 2; r++) begin
      per.delete();
      repeat (12) per.push_back(int'($urandom_range(140, 60)));
      run_phase("random", per);
    end

    // Lost PPS: one arming edge, then silence past the timeout
    start_phase();
    pps = 1'b1; tick(10); pps = 1'b0;
    tick(260);
    exp_q.push_back(16'h0C40);
    compare_writes("lost");
    check("lost_irq", {31'd0, irq}, 32'd1);
    irq_clear = 1'b1; tick(1); irq_clear = 1'b0;
    check("lost_irq_clr", {31'd0, irq}, 32'd0);
    act_q.delete(); exp_q.delete(); model_status = 8'h00;
    per = '{100};
    model_edges(per);
    drive_edges(per);
    tick(50);
    compare_writes("rearm");

    // Reset on the second byte of a write sequence
    start_phase();
    pps = 1'b1; tick(10); pps = 1'b0; tick(90); pps = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (ram_write === 1'b1 && ram_address === 8'h01) found = 1'b1;
    end
    check("rst_mid_found", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_write", {31'd0, ram_write}, 32'd0);
    check("rst_mid_cs", {31'd0, ram_chipselect}, 32'd0);
    check("rst_mid_addr", {24'd0, ram_address}, 32'd0);
    check("rst_mid_data", {24'd0, ram_writedata}, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    pps = 1'b0; enable = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(150);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0100);
    compare_writes("rst_mid");

    // 101 nominal edges: the 100 s window only exists with the macro defined
    per.delete();
    repeat (100) per.push_back(100);
    run_phase("long", per);
    hits = 0;
    last_status = 8'h00;
    foreach (act_q[i]) begin
      if (act_q[i][15:8] >= 8'h08 && act_q[i][15:8] <= 8'h0B) hits++;
      if (act_q[i][15:8] == 8'h0C) last_status = act_q[i][7:0];
    end
`ifdef VCTCXO_TAMER_PPS_100S_EN
    check("long_100s_writes", hits, 32'd4);
    check("long_status_bit2", {31'd0, last_status[2]}, 32'd1);
`else
    check("long_100s_writes", hits, 32'd0);
    check("long_status_bit2", {31'd0, last_status[2]}, 32'd0);
`endif

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vctcxo_tamer_pps_counter.md
VCTCXO_TAMER_PPS_COUNTER -- requirements
Module: vctcxo_tamer_pps_counter

Interface
REQ-001 SHALL have parameter EXPECTED_1S, default 38400000, giving the nominal clk cycles per PPS period.
REQ-002 SHALL have parameter PPS_TIMEOUT, default 76800000, giving the clk cycles without a PPS edge before the PPS is declared lost.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, derived from the VCTCXO.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: when low, measurement halts and the block returns to DISABLED.
REQ-006 SHALL have port pps, input, 1 bit: asynchronous 1PPS reference.
REQ-007 SHALL have port irq_clear, input, 1 bit: single-cycle pulse that clears irq and the sticky status.
REQ-008 SHALL have port ram_address, output, 8 bits: register RAM byte address.
REQ-009 SHALL have port ram_chipselect, output, 1 bit: RAM select, always equal to ram_write.
REQ-010 SHALL have port ram_write, output, 1 bit: one-cycle byte write strobe; the RAM accepts one write every cycle.
REQ-011 SHALL have port ram_writedata, output, 8 bits: write data.
REQ-012 SHALL have port irq, output, 1 bit: result-available interrupt to the Nios.

Function
REQ-013 SHALL synchronise pps through two flops and detect rising edges, so an edge pulse occurs 3 cycles after the pin rises.
REQ-014 SHALL implement states DISABLED, ARMING, COUNTING and WRITING.
REQ-015 DISABLED: counters are cleared; the block moves to ARMING when enable=1.
REQ-016 ARMING: the block waits for an edge pulse; on the pulse it clears the window counters and moves to COUNTING.
REQ-017 COUNTING: the 1s, 10s and 100s counters increment every cycle; each sampled count equals the number of cycles from the window-start edge pulse to the window-end edge pulse.
REQ-018 The 1s window SHALL complete on every edge, the 10s window on every 10th edge, and the 100s window on every 100th edge; each counter restarts on the completing edge with no lost cycle.
REQ-019 On completion, the block SHALL latch error = count - N*EXPECTED_1S, 32-bit two's complement, and set that window's pending flag.
REQ-020 The block SHALL enter WRITING when any pending flag is set; counting SHALL continue during WRITING.
REQ-021 WRITING SHALL service pending windows in the order 1s, 10s, 100s.
REQ-022 Each serviced window SHALL be written as 4 bytes, LSB first, to addresses base+0..3, one byte per cycle, with base 0x00 for 1s, 0x04 for 10s and 0x08 for 100s.
REQ-023 WRITING SHALL end with one status byte written to 0x0C, then return to COUNTING.
REQ-024 Status bits: bit0 = 1s updated, bit1 = 10s updated, bit2 = 100s updated, bit6 = PPS lost, bit7 = overrun; all other bits are 0.
REQ-025 Status bits SHALL be sticky until irq_clear.
REQ-026 irq SHALL rise on the cycle after the status write and hold until irq_clear.
REQ-027 If irq_clear coincides with a status write, the new bits and irq SHALL be set.
REQ-028 If a window completes while its pending flag is set, the latched error SHALL be overwritten and bit7 set.
REQ-029 If PPS_TIMEOUT cycles elapse in COUNTING with no edge, the block SHALL set bit6, write the status byte only, and return to ARMING.
REQ-030 When enable falls, the block SHALL abort any write sequence after the current cycle and move to DISABLED; pending flags are cleared.
REQ-031 When not writing, ram_write, ram_chipselect, ram_address and ram_writedata SHALL be 0.

Reset
REQ-032 On reset the state SHALL be DISABLED.
REQ-033 On reset all counters, pending flags, status bits and synchroniser flops SHALL be 0.
REQ-034 On reset all outputs SHALL be 0 on the next clk edge.
REQ-035 Reset SHALL take priority over enable, pps and irq_clear.

Configuration
REQ-036 Macro VCTCXO_TAMER_PPS_100S_EN defined: the 100s window SHALL be implemented as specified.
REQ-037 Macro VCTCXO_TAMER_PPS_100S_EN undefined: there SHALL be no 100s counter, addresses 0x08-0x0B SHALL never be written, and status bit2 SHALL be constant 0.

Verification (EXPECTED_1S=100, PPS_TIMEOUT=200)
REQ-038 Enable, pps edges every 100 cycles -> after the 2nd edge, writes 00 00 00 00 to 0x00-0x03, then 0x01 to 0x0C; irq=1.
REQ-039 Edge period 103, then 97 -> 0x00-0x03 written 03 00 00 00, then FD FF FF FF.
REQ-040 Eleven edges at period 101 -> 0x04-0x07 written 0A 00 00 00; status 0x03; the 1s bytes are written before the 10s bytes.
REQ-041 Arm, one edge, then no pps for 200 cycles -> 0x40 written to 0x0C, irq=1, state ARMING; an irq_clear pulse drops irq.
REQ-042 Reset asserted on the 2nd byte of a write sequence -> all outputs 0 next cycle, no further writes, DISABLED.
REQ-043 Macro undefined, 101 edges at period 100 -> no write to 0x08-0x0B; status bit2 = 0.
